// File: rtl/change_dispense_ctrl_pkg.sv
// Shared definitions for the vending machine coin-return path:
// coin values, one-hot coin indices and the payout FSM encoding.
package vending_machine_def;

   localparam int BAL_W_DEF = 16;

   localparam int COIN_100  = 100;
   localparam int COIN_500  = 500;
   localparam int COIN_1000 = 1000;

   localparam int IDX_100  = 0;
   localparam int IDX_500  = 1;
   localparam int IDX_1000 = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SELECT,
      ST_PRESENT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/change_dispense_ctrl_coin_inventory.sv
// Saturating up/down coin counter; reset loads INIT.
// Simultaneous credit and debit leave the count unchanged.
module coin_inventory #(
   parameter int CNT_W = 8,
   parameter int INIT  = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_count
);

   localparam logic [CNT_W-1:0] MAX = '1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_count <= CNT_W'(INIT);
      end else if (i_inc && !i_dec && o_count != MAX) begin
         o_count <= o_count + 1'b1;
      end else if (i_dec && !i_inc && o_count != '0) begin
         o_count <= o_count - 1'b1;
      end
   end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Coin-return sequencer: pays the balance largest coin first, one per handshake.
// Optional idle auto-return is enabled with RETURN_TIMEOUT_EN.
module change_dispense_ctrl
   import vending_machine_def::*;
#(
   parameter int BAL_W     = BAL_W_DEF,
   parameter int CNT_W     = 8,
   parameter int INIT_100  = 20,
   parameter int INIT_500  = 10,
   parameter int INIT_1000 = 5
`ifdef RETURN_TIMEOUT_EN
   ,parameter int TIMEOUT  = 10
`endif
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_start,
   input  logic [BAL_W-1:0] i_balance,
   input  logic [2:0]       i_coin_in,
   output logic [2:0]       o_coin_valid,
   input  logic             i_coin_ready,
`ifdef RETURN_TIMEOUT_EN
   input  logic             i_activity,
   output logic             o_timeout,
`endif
   output logic             o_busy,
   output logic             o_done,
   output logic [BAL_W-1:0] o_shortfall,
   output logic [CNT_W-1:0] o_inv_100,
   output logic [CNT_W-1:0] o_inv_500,
   output logic [CNT_W-1:0] o_inv_1000
);

   state_t           r_state;
   logic [BAL_W-1:0] r_remaining;
   logic [2:0]       r_coin;

   logic [2:0]       w_pick;
   logic [BAL_W-1:0] w_coin_val;
   logic             w_hs;
   logic [2:0]       w_dec;
   logic             w_go;

   // Greedy choice: largest coin that fits and is in stock
   always_comb begin
      w_pick = '0;
      if (r_remaining >= BAL_W'(COIN_1000) && o_inv_1000 != '0) begin
         w_pick[IDX_1000] = 1'b1;
      end else if (r_remaining >= BAL_W'(COIN_500) && o_inv_500 != '0) begin
         w_pick[IDX_500] = 1'b1;
      end else if (r_remaining >= BAL_W'(COIN_100) && o_inv_100 != '0) begin
         w_pick[IDX_100] = 1'b1;
      end
   end

   always_comb begin
      w_coin_val = '0;
      unique case (1'b1)
         r_coin[IDX_1000]: w_coin_val = BAL_W'(COIN_1000);
         r_coin[IDX_500]:  w_coin_val = BAL_W'(COIN_500);
         r_coin[IDX_100]:  w_coin_val = BAL_W'(COIN_100);
         default:          w_coin_val = '0;
      endcase
   end

   assign w_hs  = (r_state == ST_PRESENT) && i_coin_ready;
   assign w_dec = w_hs ? r_coin : 3'b000;

`ifdef RETURN_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] r_idle_cnt;
   logic            w_clr;
   logic            w_fire;

   assign w_clr  = i_activity | (|i_coin_in) | i_start;
   assign w_fire = (r_state == ST_IDLE) && !w_clr &&
                   (i_balance != '0) &&
                   (r_idle_cnt == TO_W'(TIMEOUT - 1));
   assign w_go   = i_start | w_fire;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idle_cnt <= '0;
         o_timeout  <= 1'b0;
      end else begin
         o_timeout <= w_fire;
         if (r_state != ST_IDLE || w_clr ||
             i_balance == '0 || w_fire) begin
            r_idle_cnt <= '0;
         end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
         end
      end
   end
`else
   assign w_go = i_start;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_remaining  <= '0;
         r_coin       <= '0;
         o_coin_valid <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_shortfall  <= '0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_go) begin
                  r_remaining <= i_balance;
                  o_shortfall <= '0;
                  o_busy      <= 1'b1;
                  r_state     <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (|w_pick) begin
                  r_coin       <= w_pick;
                  o_coin_valid <= w_pick;
                  r_state      <= ST_PRESENT;
               end else begin
                  o_shortfall <= r_remaining;
                  o_done      <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_PRESENT: begin
               if (i_coin_ready) begin
                  r_remaining  <= r_remaining - w_coin_val;
                  o_coin_valid <= '0;
                  r_state      <= ST_SELECT;
               end
            end
            ST_DONE: begin
               o_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   coin_inventory #(.CNT_W(CNT_W), .INIT(INIT_100)) u_inv_100 (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (i_coin_in[IDX_100]),
      .i_dec   (w_dec[IDX_100]),
      .o_count (o_inv_100)
   );

   coin_inventory #(.CNT_W(CNT_W), .INIT(INIT_500)) u_inv_500 (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (i_coin_in[IDX_500]),
      .i_dec   (w_dec[IDX_500]),
      .o_count (o_inv_500)
   );

   coin_inventory #(.CNT_W(CNT_W), .INIT(INIT_1000)) u_inv_1000 (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (i_coin_in[IDX_1000]),
      .i_dec   (w_dec[IDX_1000]),
      .o_count (o_inv_1000)
   );

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Randomized bench for change_dispense_ctrl against a greedy payout model.
// Define RETURN_TIMEOUT_EN to also exercise the idle auto-return.
module tb_change_dispense_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_start = 1'b0;
   logic [15:0] i_balance = '0;
   logic [2:0]  i_coin_in = '0;
   logic [2:0]  o_coin_valid;
   logic        i_coin_ready = 1'b0;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_shortfall;
   logic [7:0]  o_inv_100;
   logic [7:0]  o_inv_500;
   logic [7:0]  o_inv_1000;
`ifdef RETURN_TIMEOUT_EN
   logic        i_activity = 1'b0;
   logic        o_timeout;
`endif

   change_dispense_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_start      (i_start),
      .i_balance    (i_balance),
      .i_coin_in    (i_coin_in),
      .o_coin_valid (o_coin_valid),
      .i_coin_ready (i_coin_ready),
`ifdef RETURN_TIMEOUT_EN
      .i_activity   (i_activity),
      .o_timeout    (o_timeout),
`endif
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_shortfall  (o_shortfall),
      .o_inv_100    (o_inv_100),
      .o_inv_500    (o_inv_500),
      .o_inv_1000   (o_inv_1000)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int val[3]   = '{100, 500, 1000};
   int init_v[3] = '{20, 10, 5};
   int m_inv[3];

   // Model: largest coin that fits the remainder and is in stock
   function automatic int pick(input int rem);
      for (int d = 2; d >= 0; d--) begin
         if (rem >= val[d] && m_inv[d] > 0) return d;
      end
      return -1;
   endfunction

   function automatic int dut_inv(input int d);
      case (d)
         0:       return int'(o_inv_100);
         1:       return int'(o_inv_500);
         default: return int'(o_inv_1000);
      endcase
   endfunction

   function automatic void model_edge(input logic [2:0] cin, input int deb);
      for (int d = 0; d < 3; d++) begin
         if (cin[d] && deb != d) begin
            if (m_inv[d] < 255) m_inv[d]++;
         end else if (!cin[d] && deb == d) begin
            m_inv[d]--;
         end
      end
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) m_inv[d] = init_v[d];
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_coin_valid !== 3'b000 ||
          o_shortfall !== 16'd0) begin
         errors++;
         $display("FAIL reset_outs: busy=%b done=%b valid=%b short=%0d required 0",
                  o_busy, o_done, o_coin_valid, o_shortfall);
      end
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (dut_inv(d) !== init_v[d]) begin
            errors++;
            $display("FAIL reset_inv%0d: got %0d required %0d",
                     val[d], dut_inv(d), init_v[d]);
         end
      end
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_payout(input int bal, input bit bp, input bit rnd,
                             input logic [2:0] hs_cin, input string tag);
      int rem;
      int d;
      int hold;
      int ncoin;
      logic [2:0] cin;
      logic [2:0] exp_v;
      rem = bal;
      ncoin = 0;
      i_balance = 16'(bal);
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      i_balance = 16'($urandom);
      checks++;
      if (o_busy !== 1'b1 || o_shortfall !== 16'd0) begin
         errors++;
         $display("FAIL %s start: busy=%b short=%0d required 1/0",
                  tag, o_busy, o_shortfall);
      end
      while (1) begin
         d = pick(rem);
         @(posedge clk);
         #1;
         if (d < 0) break;
         exp_v = 3'b001 << d;
         checks++;
         if (o_coin_valid !== exp_v) begin
            errors++;
            $display("FAIL %s coin%0d: valid=%b required %b",
                     tag, ncoin, o_coin_valid, exp_v);
         end
         hold = bp ? $urandom_range(0, 3) : 0;
         repeat (hold) begin
            cin = rnd ? 3'($urandom) : 3'b000;
            i_coin_in = cin;
            if (rnd) i_start = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            i_coin_in = '0;
            i_start = 1'b0;
            model_edge(cin, -1);
            checks++;
            if (o_coin_valid !== exp_v) begin
               errors++;
               $display("FAIL %s hold_valid: valid=%b required %b",
                        tag, o_coin_valid, exp_v);
            end
            for (int k = 0; k < 3; k++) begin
               checks++;
               if (dut_inv(k) !== m_inv[k]) begin
                  errors++;
                  $display("FAIL %s hold_inv%0d: got %0d required %0d",
                           tag, val[k], dut_inv(k), m_inv[k]);
               end
            end
         end
         cin = rnd ? 3'($urandom) : hs_cin;
         i_coin_in = cin;
         i_coin_ready = 1'b1;
         @(posedge clk);
         #1;
         i_coin_in = '0;
         i_coin_ready = 1'b0;
         model_edge(cin, d);
         rem -= val[d];
         ncoin++;
         checks++;
         if (o_coin_valid !== 3'b000) begin
            errors++;
            $display("FAIL %s accept_valid: valid=%b required 000",
                     tag, o_coin_valid);
         end
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (dut_inv(k) !== m_inv[k]) begin
               errors++;
               $display("FAIL %s inv%0d: got %0d required %0d",
                        tag, val[k], dut_inv(k), m_inv[k]);
            end
         end
         if (ncoin > 700) begin
            errors++;
            $display("FAIL %s coin_bound: more than 700 coins", tag);
            break;
         end
      end
      checks++;
      if (o_done !== 1'b1 || o_coin_valid !== 3'b000 ||
          o_shortfall !== 16'(rem)) begin
         errors++;
         $display("FAIL %s done: done=%b valid=%b short=%0d required 1/000/%0d",
                  tag, o_done, o_coin_valid, o_shortfall, rem);
      end
      i_balance = '0;
      @(posedge clk);
      #1;
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_shortfall !== 16'(rem)) begin
         errors++;
         $display("FAIL %s idle: done=%b busy=%b short=%0d required 0/0/%0d",
                  tag, o_done, o_busy, o_shortfall, rem);
      end
   endtask

   task automatic test_basic();
      run_payout(2800, 0, 0, 3'b000, "basic2800");
      checks++;
      if (o_inv_1000 !== 8'd3 || o_inv_500 !== 8'd9 || o_inv_100 !== 8'd17) begin
         errors++;
         $display("FAIL basic_inv: 1000=%0d 500=%0d 100=%0d required 3/9/17",
                  o_inv_1000, o_inv_500, o_inv_100);
      end
   endtask

   task automatic test_drain_1000();
      run_payout(2000, 0, 0, 3'b000, "drain2000");
      run_payout(4800, 0, 0, 3'b000, "pay4800");
      checks++;
      if (o_inv_1000 !== 8'd0 || o_inv_500 !== 8'd2 || o_inv_100 !== 8'd14) begin
         errors++;
         $display("FAIL drain_inv: 1000=%0d 500=%0d 100=%0d required 0/2/14",
                  o_inv_1000, o_inv_500, o_inv_100);
      end
   endtask

   task automatic test_shortfall();
      run_payout(250, 0, 0, 3'b000, "short250");
      checks++;
      if (o_shortfall !== 16'd50) begin
         errors++;
         $display("FAIL short250_val: got %0d required 50", o_shortfall);
      end
      run_payout(1400, 1, 0, 3'b000, "pay1400");
      run_payout(m_inv[0] * 100 + 200, 0, 0, 3'b000, "exhaust100");
      checks++;
      if (o_shortfall !== 16'd200 || o_inv_100 !== 8'd0) begin
         errors++;
         $display("FAIL exhaust_val: short=%0d inv100=%0d required 200/0",
                  o_shortfall, o_inv_100);
      end
      run_payout(300, 0, 0, 3'b000, "empty300");
      run_payout(0, 0, 0, 3'b000, "zero");
   endtask

   task automatic test_saturation();
      i_balance = '0;
      repeat (300) begin
         i_coin_in = 3'b111;
         @(posedge clk);
         #1;
         model_edge(3'b111, -1);
      end
      i_coin_in = '0;
      checks++;
      if (o_inv_100 !== 8'd255 || o_inv_500 !== 8'd255 || o_inv_1000 !== 8'd255) begin
         errors++;
         $display("FAIL saturate: 100=%0d 500=%0d 1000=%0d required 255",
                  o_inv_100, o_inv_500, o_inv_1000);
      end
   endtask

   task automatic test_same_edge();
      run_payout(500, 0, 0, 3'b010, "same_edge500");
      checks++;
      if (o_inv_500 !== 8'd255) begin
         errors++;
         $display("FAIL same_edge_inv500: got %0d required 255", o_inv_500);
      end
   endtask

   task automatic test_backpressure();
      run_payout(3700, 1, 1, 3'b000, "bp3700");
      run_payout(1900, 1, 1, 3'b000, "bp1900");
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         run_payout($urandom_range(0, 6000), 1, 1, 3'b000, "random");
      end
   endtask

   task automatic test_reset_mid();
      i_balance = 16'd1500;
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      i_balance = '0;
      @(posedge clk);
      #1;
      checks++;
      if (o_coin_valid !== 3'b100) begin
         errors++;
         $display("FAIL rmid_offer: valid=%b required 100", o_coin_valid);
      end
      #2;
      reset_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) m_inv[d] = init_v[d];
      checks++;
      if (o_coin_valid !== 3'b000 || o_busy !== 1'b0 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL rmid_async: valid=%b busy=%b done=%b required 0",
                  o_coin_valid, o_busy, o_done);
      end
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (dut_inv(d) !== m_inv[d]) begin
            errors++;
            $display("FAIL rmid_inv%0d: got %0d required %0d",
                     val[d], dut_inv(d), m_inv[d]);
         end
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         checks++;
         if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_nodone: done=%b busy=%b required 0/0",
                     o_done, o_busy);
         end
      end
   endtask

`ifdef RETURN_TIMEOUT_EN
   task automatic test_timeout();
      int cnt;
      i_activity = 1'b0;
      i_balance = 16'd500;
      cnt = 0;
      while (o_timeout !== 1'b1 && cnt < 30) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      i_balance = '0;
      checks++;
      if (cnt !== 10 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_fire: cycles=%0d busy=%b required 10/1",
                  cnt, o_busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (o_coin_valid !== 3'b010 || o_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_coin: valid=%b pulse=%b required 010/0",
                  o_coin_valid, o_timeout);
      end
      i_coin_ready = 1'b1;
      @(posedge clk);
      #1;
      i_coin_ready = 1'b0;
      model_edge(3'b000, 1);
      @(posedge clk);
      #1;
      checks++;
      if (o_done !== 1'b1 || o_shortfall !== 16'd0 ||
          int'(o_inv_500) !== m_inv[1]) begin
         errors++;
         $display("FAIL timeout_done: done=%b short=%0d inv500=%0d required 1/0/%0d",
                  o_done, o_shortfall, o_inv_500, m_inv[1]);
      end
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_drain_1000();
      test_shortfall();
      test_saturation();
      test_same_edge();
      test_backpressure();
      test_random();
      test_reset_mid();
`ifdef RETURN_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
